// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown timer.
//   bcd_digit_t       - one packed BCD digit (4 bits)
//   countdown_state_t - controller states
//   BCD_MAX           - largest legal BCD digit value
//   clamp_digit()     - saturates an illegal digit (A..F) to 9
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StExpired
  } countdown_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/prev_digit.sv
// Combinational multi-digit BCD decrement.
//   value_i  - packed BCD input, digit 0 least significant
//   value_o  - value_i minus one, in BCD
//   borrow_o - set when value_i was zero (result wraps to all nines)
module prev_digit
  import bcd_pkg::*;
#(
  parameter int unsigned Digits = 6
) (
  input  bcd_digit_t [Digits-1:0] value_i,
  output bcd_digit_t [Digits-1:0] value_o,
  output logic                    borrow_o
);

  logic borrow;

  // Borrow ripples upward through zero digits and stops at the first nonzero one.
  always_comb begin
    value_o = value_i;
    borrow  = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (borrow) begin
        if (value_i[i] == '0) begin
          value_o[i] = BCD_MAX;
        end else begin
          value_o[i] = value_i[i] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
    borrow_o = borrow;
  end

endmodule

// File: rtl/bcd_countdown.sv
// Prescaled BCD countdown timer with load, start/pause and optional auto-reload.
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   load       - parallel load strobe (highest priority)
//   load_value - packed BCD preset; digits above 9 load as 9
//   start      - begin / resume counting
//   pause      - suspend counting
//   bcd_out    - registered current count
//   running    - high while in the run state
//   done       - registered one-cycle expiry (or reload) pulse
//   zero       - high when every digit of bcd_out is zero
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          RELOAD   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  bcd_digit_t [DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  output bcd_digit_t [DIGITS-1:0] bcd_out,
  output logic                    running,
  output logic                    done,
  output logic                    zero
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  countdown_state_t        state_q, state_d;
  bcd_digit_t [DIGITS-1:0] bcd_q, bcd_d;
  bcd_digit_t [DIGITS-1:0] reload_q, reload_d;
  logic [PrescW-1:0]       presc_q, presc_d;
  logic                    done_q, done_d;

  bcd_digit_t [DIGITS-1:0] load_clamped;
  bcd_digit_t [DIGITS-1:0] dec_value;
  logic                    dec_borrow;
  logic                    tick;
  logic                    last_tick;

  prev_digit #(
    .Digits (DIGITS)
  ) u_prev_digit (
    .value_i  (bcd_q),
    .value_o  (dec_value),
    .borrow_o (dec_borrow)
  );

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i] = clamp_digit(load_value[i]);
    end
  end

  assign tick      = (presc_q == PrescMax);
  // Decrement lands on zero only when counting down from exactly one.
  assign last_tick = (dec_value == '0) && !dec_borrow;

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    if (load) begin
      bcd_d    = load_clamped;
      reload_d = load_clamped;
      presc_d  = '0;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (bcd_q != '0)) state_d = StRun;
        end
        StRun: begin
          // A tick is consumed even when pause arrives with it; otherwise pause freezes
          // the prescaler so resume continues from the same phase.
          if (tick)        presc_d = '0;
          else if (!pause) presc_d = presc_q + PrescW'(1);
          if (pause) state_d = StPaused;
          if (tick) begin
            if (last_tick) begin
              done_d = 1'b1;
              if (RELOAD) begin
                bcd_d = reload_q;
              end else begin
                bcd_d   = '0;
                state_d = StExpired;
              end
            end else begin
              bcd_d = dec_value;
            end
          end
        end
        StPaused: begin
          if (start && !pause) state_d = StRun;
        end
        StExpired: begin
          state_d = StExpired;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      bcd_q    <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign bcd_out = bcd_q;
  assign running = (state_q == StRun);
  assign done    = done_q;
  assign zero    = (bcd_q == '0);

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench for bcd_countdown: one instance with RELOAD=0, one with RELOAD=1,
// both DIGITS=6, TICK_DIV=4. Expected tick results go through a scoreboard queue.
module tb_bcd_countdown;
  import bcd_pkg::*;

  localparam int unsigned Digits  = 6;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned W       = Digits * 4;

  typedef struct packed {
    logic [W-1:0] bcd;
    logic         done;
    logic         running;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         load0, start0, pause0, run0, done0, zero0;
  logic [W-1:0] lv0, bcd0;
  logic         load1, start1, pause1, run1, done1, zero1;
  logic [W-1:0] lv1, bcd1;

  logic         sel;
  logic [W-1:0] obs_bcd;
  logic         obs_done, obs_run;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bcd_countdown #(
    .DIGITS   (Digits),
    .TICK_DIV (TickDiv),
    .RELOAD   (1'b0)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .load       (load0),
    .load_value (lv0),
    .start      (start0),
    .pause      (pause0),
    .bcd_out    (bcd0),
    .running    (run0),
    .done       (done0),
    .zero       (zero0)
  );

  bcd_countdown #(
    .DIGITS   (Digits),
    .TICK_DIV (TickDiv),
    .RELOAD   (1'b1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .load       (load1),
    .load_value (lv1),
    .start      (start1),
    .pause      (pause1),
    .bcd_out    (bcd1),
    .running    (run1),
    .done       (done1),
    .zero       (zero1)
  );

  assign obs_bcd  = sel ? bcd1 : bcd0;
  assign obs_done = sel ? done1 : done0;
  assign obs_run  = sel ? run1 : run0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [W-1:0] b, input logic d, input logic r);
    exp_t e;
    e.bcd     = b;
    e.done    = d;
    e.running = r;
    sb_q.push_back(e);
  endtask

  // Called right after the edge that starts (or last ticked) the count: each expected tick
  // arrives TickDiv edges later, with the value held and done low on the edge before.
  task automatic drain(input logic [W-1:0] start_val);
    logic [W-1:0] prev;
    exp_t         e;
    prev = start_val;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(TickDiv - 1);
      check_eq("sb_hold_bcd", obs_bcd, prev);
      check_eq("sb_hold_done", obs_done, 1'b0);
      step(1);
      check_eq("sb_bcd", obs_bcd, e.bcd);
      check_eq("sb_done", obs_done, e.done);
      check_eq("sb_running", obs_run, e.running);
      prev = e.bcd;
    end
  endtask

  task automatic load_dut0(input logic [W-1:0] v);
    load0 = 1'b1;
    lv0   = v;
    step(1);
    load0 = 1'b0;
  endtask

  task automatic start_dut0();
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sel    = 1'b0;
    load0  = 1'b0; start0 = 1'b0; pause0 = 1'b0; lv0 = '0;
    load1  = 1'b0; start1 = 1'b0; pause1 = 1'b0; lv1 = '0;
    step(2);
    check_eq("rst_bcd", bcd0, 24'h000000);
    check_eq("rst_zero", zero0, 1'b1);
    check_eq("rst_running", run0, 1'b0);
    check_eq("rst_done", done0, 1'b0);
    reset = 1'b0;
    step(1);

    // Start with a zero count must not run.
    start_dut0();
    check_eq("start_zero_running", run0, 1'b0);
    check_eq("start_zero_done", done0, 1'b0);

    // Count down 3 -> 0 and expire.
    load_dut0(24'h000003);
    check_eq("load3_bcd", bcd0, 24'h000003);
    check_eq("load3_zero", zero0, 1'b0);
    start_dut0();
    check_eq("start_latency", run0, 1'b1);
    push_exp(24'h000002, 1'b0, 1'b1);
    push_exp(24'h000001, 1'b0, 1'b1);
    push_exp(24'h000000, 1'b1, 1'b0);
    drain(24'h000003);
    check_eq("expire_zero", zero0, 1'b1);
    step(1);
    check_eq("done_one_cycle", done0, 1'b0);
    start_dut0();
    check_eq("expired_ignores_start", run0, 1'b0);
    step(5);
    check_eq("expired_bcd_hold", bcd0, 24'h000000);
    check_eq("expired_done_low", done0, 1'b0);

    // Borrow across many digits.
    load_dut0(24'h100000);
    start_dut0();
    push_exp(24'h099999, 1'b0, 1'b1);
    drain(24'h100000);
    load_dut0(24'h000010);
    check_eq("load_mid_run_idle", run0, 1'b0);
    check_eq("load10_bcd", bcd0, 24'h000010);
    start_dut0();
    push_exp(24'h000009, 1'b0, 1'b1);
    drain(24'h000010);

    // Illegal digits saturate to 9.
    load_dut0(24'h00000F);
    check_eq("clamp_low", bcd0, 24'h000009);
    load_dut0(24'h0A0000);
    check_eq("clamp_mid", bcd0, 24'h090000);
    load_dut0(24'hABCDEF);
    check_eq("clamp_all", bcd0, 24'h999999);

    // Pause at prescaler count 2, hold, then resume from the same phase.
    load_dut0(24'h000005);
    start_dut0();
    step(2);
    pause0 = 1'b1;
    step(1);
    pause0 = 1'b0;
    check_eq("pause_running", run0, 1'b0);
    step(20);
    check_eq("pause_bcd_hold", bcd0, 24'h000005);
    check_eq("pause_running_hold", run0, 1'b0);
    start_dut0();
    check_eq("resume_running", run0, 1'b1);
    step(1);
    check_eq("resume_before_tick", bcd0, 24'h000005);
    step(1);
    check_eq("resume_tick", bcd0, 24'h000004);

    // start+pause together: pause wins in RUN, stays paused in PAUSED.
    start0 = 1'b1;
    pause0 = 1'b1;
    step(1);
    check_eq("pause_wins_run", run0, 1'b0);
    step(1);
    check_eq("pause_wins_paused", run0, 1'b0);
    start0 = 1'b0;
    pause0 = 1'b0;
    step(8);
    check_eq("paused_bcd_hold", bcd0, 24'h000004);

    // Asynchronous reset in the middle of a run.
    start_dut0();
    check_eq("rerun_running", run0, 1'b1);
    step(1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_bcd", bcd0, 24'h000000);
    check_eq("async_rst_zero", zero0, 1'b1);
    check_eq("async_rst_running", run0, 1'b0);
    check_eq("async_rst_done", done0, 1'b0);
    step(1);
    reset = 1'b0;
    step(1);
    start_dut0();
    check_eq("post_rst_start", run0, 1'b0);

    // Auto-reload instance.
    sel   = 1'b1;
    load1 = 1'b1;
    lv1   = 24'h000002;
    step(1);
    load1 = 1'b0;
    check_eq("rl_load_bcd", bcd1, 24'h000002);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    check_eq("rl_running", run1, 1'b1);
    push_exp(24'h000001, 1'b0, 1'b1);
    push_exp(24'h000002, 1'b1, 1'b1);
    push_exp(24'h000001, 1'b0, 1'b1);
    push_exp(24'h000002, 1'b1, 1'b1);
    drain(24'h000002);
    step(1);
    check_eq("rl_done_drop", done1, 1'b0);
    check_eq("rl_still_running", run1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
